// File: rtl/cvxif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_pkg
//  Description : Shared types and constants for the simplified CVXIF issuer
//                and the posit PAU responder: issuer FSM state encoding,
//                custom-3 opcode and the arithmetic funct3 codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cvxif_pkg;

    // Issuer FSM states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        REGS        = 3'd2,
        WAIT_RESULT = 3'd3,
        RESP        = 3'd4
    } state_t;

    // Major opcode used by the coprocessor (custom-3)
    localparam logic [6:0] CUSTOM3_OPCODE = 7'b1111011;

    // funct3 operation selectors understood by the PAU
    localparam logic [2:0] FUNCT3_ADD = 3'b000;
    localparam logic [2:0] FUNCT3_SUB = 3'b001;
    localparam logic [2:0] FUNCT3_MUL = 3'b010;
    localparam logic [2:0] FUNCT3_DIV = 3'b011;

    // Destination register field of a RISC-V R-type instruction
    function automatic logic [4:0] get_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cvxif_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_watchdog
//  Description : Cycle counter used by the issuer to bound time spent waiting
//                on the responder. Counts while i_active is high, restarts
//                from zero whenever i_active is low, and flags o_expired on
//                the TIMEOUT_CYCLES-th consecutive active cycle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_active      - issuer is in a waiting state
//                o_expired     - limit reached this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module cvxif_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    output logic o_expired
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  C_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Leaving the waiting states clears the count, so every entry starts fresh
    always_ff @(posedge clk) begin
        if (rst || !i_active) begin
            r_cnt <= '0;
        end else if (!o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_active && (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/cvxif_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_issuer
//  Description : CPU-side initiator of the simplified CVXIF. Accepts one
//                command (instr, rs1, rs2), issues it to a responder, supplies
//                operands, collects the result and returns one response
//                record. Only one operation is in flight at a time.
//  Config      : CVXIF_ISSUER_TIMEOUT_EN - when defined, a watchdog bounds the
//                ISSUE and WAIT_RESULT states to TIMEOUT_CYCLES cycles each.
//  Ports       : clk, rst                     clock / sync active-high reset
//                i_cmd_* / o_cmd_ready        command channel from the core
//                o_rsp_* / i_rsp_ready        response channel to the core
//                o_issue_* / i_issue_*        CVXIF issue channel
//                o_register_* / i_register_ready  CVXIF operand channel
//                i_result_* / o_result_ready  CVXIF result channel
//  Revision    : 1.0 - initial release
// ============================================================================
module cvxif_issuer
    import cvxif_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_HS         = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    // command channel
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [31:0]     i_cmd_instr,
    input  logic [XLEN-1:0] i_cmd_rs1,
    input  logic [XLEN-1:0] i_cmd_rs2,
    // response channel
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_data,
    output logic [4:0]      o_rsp_rd,
    output logic            o_rsp_accepted,
    output logic            o_rsp_timeout,
    // CVXIF issue
    output logic            o_issue_valid,
    input  logic            i_issue_ready,
    output logic [31:0]     o_issue_req_instr,
    input  logic            i_issue_resp_accept,
    input  logic            i_issue_resp_writeback,
    input  logic [1:0]      i_issue_resp_register_read,
    // CVXIF register
    output logic            o_register_valid,
    input  logic            i_register_ready,
    output logic [XLEN-1:0] o_register_rs [0:1],
    output logic [1:0]      o_register_rs_valid,
    // CVXIF result
    input  logic            i_result_valid,
    output logic            o_result_ready,
    input  logic [XLEN-1:0] i_result_data
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic            r_accept;
    logic            r_writeback;
    logic [1:0]      r_reg_read;
    logic [XLEN-1:0] r_rsp_data;
    logic            w_expired;
    logic            w_regs_done;

    // With REG_HS=0 the operand beat is a one-cycle pulse and register_ready
    // is not consulted.
    assign w_regs_done = (REG_HS == 0) || i_register_ready;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs. Every valid/ready is forced low while
    // rst is asserted, including the first reset cycle of an aborted op.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        o_cmd_ready      = 1'b0;
        o_issue_valid    = 1'b0;
        o_register_valid = 1'b0;
        o_result_ready   = 1'b0;
        o_rsp_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                o_cmd_ready = !rst;
                if (i_cmd_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                o_issue_valid = !rst;
                if (i_issue_ready) begin
                    w_state_nxt = i_issue_resp_accept ? REGS : RESP;
                end else if (w_expired) begin
                    w_state_nxt = RESP;
                end
            end
            REGS: begin
                o_register_valid = !rst;
                if (w_regs_done) begin
                    w_state_nxt = r_writeback ? WAIT_RESULT : RESP;
                end
            end
            WAIT_RESULT: begin
                o_result_ready = !rst;
                if (i_result_valid) begin
                    w_state_nxt = RESP;
                end else if (w_expired) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = !rst;
                if (i_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operation context and response payload. rsp_data is cleared when a
    // command is taken and only loaded by a real result, so rejected,
    // no-writeback and timed-out ops all report zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_accept    <= 1'b0;
            r_writeback <= 1'b0;
            r_reg_read  <= 2'b00;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_instr     <= i_cmd_instr;
                        r_rs1       <= i_cmd_rs1;
                        r_rs2       <= i_cmd_rs2;
                        r_accept    <= 1'b0;
                        r_writeback <= 1'b0;
                        r_reg_read  <= 2'b00;
                        r_rsp_data  <= '0;
                    end
                end
                ISSUE: begin
                    if (i_issue_ready) begin
                        r_accept    <= i_issue_resp_accept;
                        r_writeback <= i_issue_resp_writeback;
                        r_reg_read  <= i_issue_resp_register_read;
                    end
                end
                WAIT_RESULT: begin
                    if (i_result_valid) begin
                        r_rsp_data <= i_result_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_issue_req_instr   = r_instr;
    assign o_register_rs[0]    = r_rs1;
    assign o_register_rs[1]    = r_rs2;
    assign o_register_rs_valid = r_reg_read;
    assign o_rsp_data          = r_rsp_data;
    assign o_rsp_rd            = get_rd(r_instr);
    assign o_rsp_accepted      = r_accept;

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef CVXIF_ISSUER_TIMEOUT_EN
    logic w_wd_active;
    logic r_timeout;

    assign w_wd_active = (r_state == ISSUE) || (r_state == WAIT_RESULT);

    cvxif_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_active  (w_wd_active),
        .o_expired (w_expired)
    );

    // A handshake landing on the expiry cycle wins over the timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (r_state == IDLE && i_cmd_valid) begin
            r_timeout <= 1'b0;
        end else if (w_expired &&
                     ((r_state == ISSUE && !i_issue_ready) ||
                      (r_state == WAIT_RESULT && !i_result_valid))) begin
            r_timeout <= 1'b1;
        end
    end

    assign o_rsp_timeout = r_timeout;
`else
    logic w_unused_timeout;

    assign w_expired        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign o_rsp_timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cvxif_issuer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cvxif_issuer
//  Description : Self-checking bench for cvxif_issuer. Two instances share
//                stimulus: u_dut (REG_HS=0) and u_hs (REG_HS=1). A responder
//                process models the coprocessor; expected responses are
//                queued when a command is driven and compared on arrival.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_issuer;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            acc;
        logic            to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // shared stimulus
    logic            cmd_valid = 1'b0;
    logic [31:0]     cmd_instr = '0;
    logic [XLEN-1:0] cmd_rs1 = '0, cmd_rs2 = '0;
    logic            rsp_ready = 1'b0, issue_ready = 1'b0;
    logic            issue_resp_accept = 1'b0, issue_resp_writeback = 1'b0;
    logic [1:0]      issue_resp_register_read = 2'b00;
    logic            base_reg_ready = 1'b0, h_register_ready = 1'b0;
    logic            result_valid = 1'b0;
    logic [XLEN-1:0] result_data = '0;

    // u_dut outputs
    logic            cmd_ready, rsp_valid, rsp_accepted, rsp_timeout;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd;
    logic            issue_valid, register_valid, result_ready;
    logic [31:0]     issue_req_instr;
    logic [XLEN-1:0] register_rs [0:1];
    logic [1:0]      register_rs_valid;
    // u_hs outputs
    logic            h_cmd_ready, h_rsp_valid, h_rsp_accepted, h_rsp_timeout;
    logic [XLEN-1:0] h_rsp_data;
    logic [4:0]      h_rsp_rd;
    logic            h_issue_valid, h_register_valid, h_result_ready;
    logic [31:0]     h_issue_req_instr;
    logic [XLEN-1:0] h_register_rs [0:1];
    logic [1:0]      h_register_rs_valid;

    cvxif_issuer #(.XLEN(XLEN), .REG_HS(0), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_instr(cmd_instr),
        .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_rsp_rd(rsp_rd), .o_rsp_accepted(rsp_accepted), .o_rsp_timeout(rsp_timeout),
        .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
        .o_issue_req_instr(issue_req_instr), .i_issue_resp_accept(issue_resp_accept),
        .i_issue_resp_writeback(issue_resp_writeback),
        .i_issue_resp_register_read(issue_resp_register_read),
        .o_register_valid(register_valid), .i_register_ready(base_reg_ready),
        .o_register_rs(register_rs), .o_register_rs_valid(register_rs_valid),
        .i_result_valid(result_valid), .o_result_ready(result_ready),
        .i_result_data(result_data)
    );

    cvxif_issuer #(.XLEN(XLEN), .REG_HS(1), .TIMEOUT_CYCLES(16)) u_hs (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(h_cmd_ready), .i_cmd_instr(cmd_instr),
        .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2),
        .o_rsp_valid(h_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(h_rsp_data),
        .o_rsp_rd(h_rsp_rd), .o_rsp_accepted(h_rsp_accepted), .o_rsp_timeout(h_rsp_timeout),
        .o_issue_valid(h_issue_valid), .i_issue_ready(issue_ready),
        .o_issue_req_instr(h_issue_req_instr), .i_issue_resp_accept(issue_resp_accept),
        .i_issue_resp_writeback(issue_resp_writeback),
        .i_issue_resp_register_read(issue_resp_register_read),
        .o_register_valid(h_register_valid), .i_register_ready(h_register_ready),
        .o_register_rs(h_register_rs), .o_register_rs_valid(h_register_rs_valid),
        .i_result_valid(result_valid), .o_result_ready(h_result_ready),
        .i_result_data(result_data)
    );

    // responder configuration
    logic            cfg_accept = 1'b1, cfg_wb = 1'b1, cfg_result_en = 1'b1, cfg_stray = 1'b0;
    logic [1:0]      cfg_rr = 2'b11;
    logic [XLEN-1:0] cfg_result = '0;
    int              cfg_issue_delay = 0, cfg_reg_delay = 0, cfg_rsp_delay = 0;

    int   n_checks = 0, n_pass = 0;
    int   n_iss = 0, n_rsp = 0, n_reg = 0, n_hreg = 0;
    logic [XLEN-1:0] mon_rs0, mon_rs1, mon_hrs0, mon_hrs1;
    logic [1:0]      mon_rsv, mon_hrsv;
    exp_t            sb [$];

    // Responder model, updates its outputs on the falling edge
    initial begin
        int iss_cnt, reg_cnt, rsp_cnt;
        iss_cnt = 0; reg_cnt = 0; rsp_cnt = 0;
        forever begin
            @(negedge clk);
            issue_resp_accept        = cfg_accept;
            issue_resp_writeback     = cfg_wb;
            issue_resp_register_read = cfg_rr;
            result_data              = cfg_result;
            if (issue_valid) begin
                issue_ready = (iss_cnt >= cfg_issue_delay); iss_cnt++;
            end else begin
                issue_ready = 1'b0; iss_cnt = 0;
            end
            if (h_register_valid) begin
                h_register_ready = (reg_cnt >= cfg_reg_delay); reg_cnt++;
            end else begin
                h_register_ready = 1'b0; reg_cnt = 0;
            end
            result_valid = cfg_stray || (cfg_result_en && (result_ready || h_result_ready));
            if (rsp_valid || h_rsp_valid) begin
                rsp_ready = (rsp_cnt >= cfg_rsp_delay); rsp_cnt++;
            end else begin
                rsp_ready = 1'b0; rsp_cnt = 0;
            end
        end
    end

    // Handshake monitor, samples between edges
    initial begin
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (issue_valid && issue_ready) n_iss++;
                if (rsp_valid && rsp_ready) n_rsp++;
                if (register_valid) begin
                    n_reg++; mon_rs0 = register_rs[0]; mon_rs1 = register_rs[1]; mon_rsv = register_rs_valid;
                end
                if (h_register_valid) begin
                    n_hreg++; mon_hrs0 = h_register_rs[0]; mon_hrs1 = h_register_rs[1]; mon_hrsv = h_register_rs_valid;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, got hang required completion");
        $fatal(1);
    end

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 10'b0, f3, rd, 7'b1111011};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [31:0] instr, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        cmd_valid = 1'b1; cmd_instr = instr; cmd_rs1 = a; cmd_rs2 = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Waits for u_dut rsp_valid; lat counts cycles from the command cycle
    task automatic wait_rsp(output int lat, output bit ok);
        lat = 1; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            tick(); lat++;
        end
    endtask

    task automatic test_reset();
        exp_t got;
        tick(); tick();
        n_checks++;
        if ({cmd_ready, rsp_valid, issue_valid, register_valid, result_ready,
             h_cmd_ready, h_rsp_valid, h_issue_valid, h_register_valid, h_result_ready} !== 10'b0)
            $display("FAIL reset_valids: got %b required 0", {cmd_ready, rsp_valid, issue_valid, register_valid, result_ready});
        else n_pass++;
        rst = 1'b0; #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || h_cmd_ready !== 1'b1)
            $display("FAIL reset_cmd_ready: got %b/%b required 1", cmd_ready, h_cmd_ready);
        else n_pass++;
        got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
        n_checks++;
        if (got !== '0 || issue_req_instr !== 32'h0 || register_rs[0] !== '0 || register_rs[1] !== '0)
            $display("FAIL reset_regs: got rsp=%h instr=%h required 0", got, issue_req_instr);
        else n_pass++;
    endtask

    task automatic test_add();
        int lat; bit ok; exp_t e, got; int reg0;
        cfg_accept = 1; cfg_wb = 1; cfg_rr = 2'b11; cfg_result = 32'h1234_5678;
        reg0 = n_reg;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL add_cmd_ready: got %b required 1", cmd_ready); else n_pass++;
        sb.push_back('{data: 32'h1234_5678, rd: 5'd5, acc: 1'b1, to: 1'b0});
        send_cmd(32'h0000_007B | (32'd5 << 7), 32'h11, 32'h22);
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL add_busy: cmd_ready got %b required 0", cmd_ready); else n_pass++;
        wait_rsp(lat, ok);
        n_checks++;
        if (!ok) $display("FAIL add_rsp_wait: got no rsp_valid required rsp");
        else begin
            n_pass++;
            e = sb.pop_front(); got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
            n_checks++;
            if (got !== e) $display("FAIL add_rsp: got %h required %h", got, e); else n_pass++;
            n_checks++;
            if (lat != 4) $display("FAIL add_latency: got %0d required 4", lat); else n_pass++;
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL add_release: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
        else n_pass++;
        n_checks++;
        if (n_reg - reg0 != 1 || mon_rs0 !== 32'h11 || mon_rs1 !== 32'h22 || mon_rsv !== 2'b11)
            $display("FAIL add_regs: got n=%0d rs=%h,%h v=%b required 1 11,22 11", n_reg - reg0, mon_rs0, mon_rs1, mon_rsv);
        else n_pass++;
    endtask

    task automatic test_reject();
        int lat; bit ok; exp_t e, got; int reg0;
        cfg_accept = 0; cfg_stray = 1; cfg_result = 32'hDEAD_BEEF;
        reg0 = n_reg;
        sb.push_back('{data: '0, rd: 5'd3, acc: 1'b0, to: 1'b0});
        send_cmd(mk_instr(7'h01, 3'b000, 5'd3), 32'h5, 32'h6);
        wait_rsp(lat, ok);
        n_checks++;
        if (!ok) $display("FAIL reject_rsp_wait: got no rsp_valid required rsp");
        else begin
            n_pass++;
            e = sb.pop_front(); got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
            n_checks++;
            if (got !== e) $display("FAIL reject_rsp: got %h required %h", got, e); else n_pass++;
        end
        tick();
        n_checks++;
        if (n_reg != reg0) $display("FAIL reject_no_regs: got %0d register beats required 0", n_reg - reg0); else n_pass++;
        cfg_stray = 0; cfg_accept = 1;
    endtask

    task automatic test_no_writeback();
        int lat; bit ok; exp_t e, got; int reg0;
        cfg_wb = 0; cfg_result = 32'h0000_CAFE;
        reg0 = n_reg;
        sb.push_back('{data: '0, rd: 5'd9, acc: 1'b1, to: 1'b0});
        send_cmd(mk_instr(7'h00, 3'b010, 5'd9), 32'h7, 32'h8);
        wait_rsp(lat, ok);
        n_checks++;
        if (!ok) $display("FAIL nowb_rsp_wait: got no rsp_valid required rsp");
        else begin
            n_pass++;
            e = sb.pop_front(); got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
            n_checks++;
            if (got !== e) $display("FAIL nowb_rsp: got %h required %h", got, e); else n_pass++;
        end
        tick();
        n_checks++;
        if (n_reg - reg0 != 1) $display("FAIL nowb_regs: got %0d beats required 1", n_reg - reg0); else n_pass++;
        cfg_wb = 1;
    endtask

    task automatic test_stall();
        exp_t e, got; logic [31:0] instr; int iv, rv, iss0, rsp0; bit seen;
        cfg_issue_delay = 7; cfg_rsp_delay = 3; cfg_result = 32'hA5A5_0001;
        instr = mk_instr(7'h00, 3'b001, 5'd17);
        iss0 = n_iss; rsp0 = n_rsp; iv = 0; rv = 0; seen = 0; e = '0;
        sb.push_back('{data: 32'hA5A5_0001, rd: 5'd17, acc: 1'b1, to: 1'b0});
        send_cmd(instr, 32'h1, 32'h2);
        for (int i = 0; i < 100; i++) begin
            if (issue_valid) begin
                iv++;
                n_checks++;
                if (issue_req_instr !== instr) $display("FAIL stall_instr: got %h required %h", issue_req_instr, instr);
                else n_pass++;
            end
            if (rsp_valid) begin
                if (!seen) begin seen = 1; e = sb.pop_front(); end
                rv++;
                got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
                n_checks++;
                if (got !== e) $display("FAIL stall_rsp: got %h required %h", got, e); else n_pass++;
            end else if (seen) break;
            tick();
        end
        n_checks++;
        if (iv != 8 || rv != 4) $display("FAIL stall_lengths: got issue=%0d rsp=%0d required 8/4", iv, rv); else n_pass++;
        n_checks++;
        if (n_iss - iss0 != 1 || n_rsp - rsp0 != 1)
            $display("FAIL stall_handshakes: got %0d/%0d required 1/1", n_iss - iss0, n_rsp - rsp0);
        else n_pass++;
        cfg_issue_delay = 0; cfg_rsp_delay = 0;
    endtask

    task automatic test_reg_hs();
        int lat; bit ok; exp_t e, got; int h0;
        cfg_reg_delay = 3; cfg_result = 32'h77;
        h0 = n_hreg;
        e = '{data: 32'h77, rd: 5'd12, acc: 1'b1, to: 1'b0};
        sb.push_back(e);
        send_cmd(mk_instr(7'h00, 3'b011, 5'd12), 32'hA, 32'hB);
        wait_rsp(lat, ok);
        n_checks++;
        if (!ok) $display("FAIL reghs_base_wait: got no rsp_valid required rsp");
        else begin
            n_pass++;
            e = sb.pop_front(); got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
            n_checks++;
            if (got !== e) $display("FAIL reghs_base_rsp: got %h required %h", got, e); else n_pass++;
        end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (h_rsp_valid) begin ok = 1; break; end
            tick();
        end
        n_checks++;
        if (!ok) $display("FAIL reghs_wait: got no h_rsp_valid required rsp");
        else begin
            n_pass++;
            got = {h_rsp_data, h_rsp_rd, h_rsp_accepted, h_rsp_timeout};
            n_checks++;
            if (got !== e) $display("FAIL reghs_rsp: got %h required %h", got, e); else n_pass++;
        end
        tick();
        n_checks++;
        if (n_hreg - h0 != 4 || mon_hrs0 !== 32'hA || mon_hrs1 !== 32'hB || mon_hrsv !== 2'b11)
            $display("FAIL reghs_regs: got n=%0d rs=%h,%h v=%b required 4 a,b 11", n_hreg - h0, mon_hrs0, mon_hrs1, mon_hrsv);
        else n_pass++;
        cfg_reg_delay = 0;
    endtask

    task automatic test_timeout();
        int lat; bit ok; exp_t e, got; int rr;
        cfg_result_en = 0; cfg_result = 32'h5151; rr = 0;
`ifdef CVXIF_ISSUER_TIMEOUT_EN
        sb.push_back('{data: '0, rd: 5'd21, acc: 1'b1, to: 1'b1});
        send_cmd(mk_instr(7'h00, 3'b000, 5'd21), 32'h3, 32'h4);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin ok = 1; break; end
            if (result_ready) rr++;
            tick();
        end
        n_checks++;
        if (!ok) $display("FAIL timeout_wait: got no rsp_valid required rsp");
        else begin
            n_pass++;
            e = sb.pop_front(); got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
            n_checks++;
            if (got !== e) $display("FAIL timeout_rsp: got %h required %h", got, e); else n_pass++;
            n_checks++;
            if (rr != 16 || result_ready !== 1'b0) $display("FAIL timeout_cycles: got %0d rr=%b required 16/0", rr, result_ready);
            else n_pass++;
        end
        tick();
        cfg_result_en = 1;
`else
        sb.push_back('{data: 32'h5151, rd: 5'd21, acc: 1'b1, to: 1'b0});
        send_cmd(mk_instr(7'h00, 3'b000, 5'd21), 32'h3, 32'h4);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) ok = 1;
            if (result_ready) rr++;
            tick();
        end
        n_checks++;
        if (ok || rr < 36 || result_ready !== 1'b1)
            $display("FAIL nowatchdog_wait: got rsp=%b rr=%0d required no rsp, still waiting", ok, rr);
        else n_pass++;
        cfg_result_en = 1;
        wait_rsp(lat, ok);
        n_checks++;
        if (!ok) $display("FAIL nowatchdog_rsp_wait: got no rsp_valid required rsp");
        else begin
            n_pass++;
            e = sb.pop_front(); got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
            n_checks++;
            if (got !== e) $display("FAIL nowatchdog_rsp: got %h required %h", got, e); else n_pass++;
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        bit ok; int rsp0; int seen;
        cfg_result_en = 0; rsp0 = n_rsp; ok = 0; seen = 0;
        send_cmd(mk_instr(7'h00, 3'b010, 5'd30), 32'h9, 32'h9);
        for (int i = 0; i < 20; i++) begin
            if (result_ready) begin ok = 1; break; end
            tick();
        end
        n_checks++;
        if (!ok) $display("FAIL rstmid_reach: got no WAIT_RESULT required result_ready");
        else n_pass++;
        rst = 1'b1; #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, issue_valid, register_valid, result_ready, h_result_ready} !== 6'b0)
            $display("FAIL rstmid_valids: got %b required 0", {cmd_ready, rsp_valid, issue_valid, register_valid, result_ready});
        else n_pass++;
        tick();
        rst = 1'b0; #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || h_cmd_ready !== 1'b1)
            $display("FAIL rstmid_cmd_ready: got %b/%b required 1", cmd_ready, h_cmd_ready);
        else n_pass++;
        cfg_result_en = 1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || h_rsp_valid) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0 || n_rsp != rsp0) $display("FAIL rstmid_no_rsp: got %0d rsp cycles required 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; bit ok; exp_t e, got;
        logic [XLEN-1:0] res;
        for (int k = 0; k < 4; k++) begin
            res = 32'h1000_0000 + XLEN'(k * 32'h0101_0101);
            cfg_result = res;
            sb.push_back('{data: res, rd: 5'(k + 1), acc: 1'b1, to: 1'b0});
            send_cmd(mk_instr(7'h00, 3'(k), 5'(k + 1)), XLEN'(k), XLEN'(k + 1));
            wait_rsp(lat, ok);
            n_checks++;
            if (!ok) $display("FAIL b2b_wait: op %0d got no rsp required rsp", k);
            else begin
                n_pass++;
                e = sb.pop_front(); got = {rsp_data, rsp_rd, rsp_accepted, rsp_timeout};
                n_checks++;
                if (got !== e || lat != 4) $display("FAIL b2b_rsp: op %0d got %h lat %0d required %h lat 4", k, got, lat, e);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_reject();
        test_no_writeback();
        test_stall();
        test_reg_hs();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
